// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and LSB results onto a single common data bus.
// Each source owns a circular result FIFO of DEPTH entries. Every cycle at
// most one result is granted (round-robin on ties). The grant comes from the
// FIFO head if the FIFO is non-empty, otherwise from the incoming result as a
// same-cycle bypass. The granted result is registered onto cdb_*.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; low freezes all state and drops inputs
//   clear             pipeline flush; empties both FIFOs, drops inputs
//   alu_flag/reorder/val   ALU result input
//   lsb_flag/reorder/val   LSB load result input
//   alu_stall, lsb_stall   FIFO almost full (count >= DEPTH-1)
//   cdb_flag/reorder/val/src  registered broadcast (src: 0 = ALU, 1 = LSB)
//   ovf               sticky: a result was dropped on a full FIFO
module cdb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        alu_flag,
  input  logic [3:0]  alu_reorder,
  input  logic [31:0] alu_val,
  input  logic        lsb_flag,
  input  logic [3:0]  lsb_reorder,
  input  logic [31:0] lsb_val,
  output logic        alu_stall,
  output logic        lsb_stall,
  output logic        cdb_flag,
  output logic [3:0]  cdb_reorder,
  output logic [31:0] cdb_val,
  output logic        cdb_src,
  output logic        ovf
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  logic [3:0]    alu_q_r [DEPTH];
  logic [31:0]   alu_q_v [DEPTH];
  logic [3:0]    lsb_q_r [DEPTH];
  logic [31:0]   lsb_q_v [DEPTH];
  logic [AW-1:0] alu_rd, alu_wr, lsb_rd, lsb_wr;
  logic [CW-1:0] alu_cnt, lsb_cnt;
  src_e          last_src;

  logic alu_head, lsb_head, alu_cand, lsb_cand;
  logic grant_alu, grant_lsb, grant_any;
  logic alu_pop, lsb_pop, alu_push, lsb_push, alu_drop, lsb_drop;
  logic alu_in, lsb_in;
  logic [3:0]  g_reorder;
  logic [31:0] g_val;
  logic        advance;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign advance   = rdy && !clear;
  assign alu_stall = (alu_cnt >= ALMOST);
  assign lsb_stall = (lsb_cnt >= ALMOST);

  always_comb begin
    alu_head  = (alu_cnt != '0);
    lsb_head  = (lsb_cnt != '0);
    alu_cand  = alu_head || alu_flag;
    lsb_cand  = lsb_head || lsb_flag;
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (alu_cand && lsb_cand) begin
      grant_lsb = (last_src == SRC_ALU);
      grant_alu = !grant_lsb;
    end else begin
      grant_alu = alu_cand;
      grant_lsb = lsb_cand;
    end
    grant_any = grant_alu || grant_lsb;

    alu_pop = grant_alu && alu_head;
    lsb_pop = grant_lsb && lsb_head;
    // An incoming result needs storage unless it was itself granted as bypass.
    alu_in  = alu_flag && !(grant_alu && !alu_head);
    lsb_in  = lsb_flag && !(grant_lsb && !lsb_head);
    // A full FIFO can still accept when its head leaves at the same edge.
    alu_push = alu_in && ((alu_cnt != FULL) || alu_pop);
    lsb_push = lsb_in && ((lsb_cnt != FULL) || lsb_pop);
    alu_drop = alu_in && !alu_push;
    lsb_drop = lsb_in && !lsb_push;

    g_reorder = '0;
    g_val     = '0;
    if (grant_alu) begin
      g_reorder = alu_head ? alu_q_r[alu_rd] : alu_reorder;
      g_val     = alu_head ? alu_q_v[alu_rd] : alu_val;
    end else if (grant_lsb) begin
      g_reorder = lsb_head ? lsb_q_r[lsb_rd] : lsb_reorder;
      g_val     = lsb_head ? lsb_q_v[lsb_rd] : lsb_val;
    end
  end

  // Storage has no reset; validity is tracked entirely by the pointers/counts.
  always_ff @(posedge clk) begin
    if (!rst && advance) begin
      if (alu_push) begin
        alu_q_r[alu_wr] <= alu_reorder;
        alu_q_v[alu_wr] <= alu_val;
      end
      if (lsb_push) begin
        lsb_q_r[lsb_wr] <= lsb_reorder;
        lsb_q_v[lsb_wr] <= lsb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_rd      <= '0;
      alu_wr      <= '0;
      alu_cnt     <= '0;
      lsb_rd      <= '0;
      lsb_wr      <= '0;
      lsb_cnt     <= '0;
      last_src    <= SRC_LSB;
      cdb_flag    <= 1'b0;
      cdb_reorder <= '0;
      cdb_val     <= '0;
      cdb_src     <= 1'b0;
      ovf         <= 1'b0;
    end else if (!rdy) begin
      cdb_flag <= 1'b0;
    end else if (clear) begin
      alu_rd   <= '0;
      alu_wr   <= '0;
      alu_cnt  <= '0;
      lsb_rd   <= '0;
      lsb_wr   <= '0;
      lsb_cnt  <= '0;
      cdb_flag <= 1'b0;
    end else begin
      cdb_flag <= grant_any;
      if (grant_any) begin
        cdb_reorder <= g_reorder;
        cdb_val     <= g_val;
        cdb_src     <= grant_lsb;
        last_src    <= grant_lsb ? SRC_LSB : SRC_ALU;
      end
      if (alu_pop)  alu_rd <= ptr_inc(alu_rd);
      if (alu_push) alu_wr <= ptr_inc(alu_wr);
      if (lsb_pop)  lsb_rd <= ptr_inc(lsb_rd);
      if (lsb_push) lsb_wr <= ptr_inc(lsb_wr);
      if (alu_push && !alu_pop)      alu_cnt <= alu_cnt + 1'b1;
      else if (alu_pop && !alu_push) alu_cnt <= alu_cnt - 1'b1;
      if (lsb_push && !lsb_pop)      lsb_cnt <= lsb_cnt + 1'b1;
      else if (lsb_pop && !lsb_push) lsb_cnt <= lsb_cnt - 1'b1;
      if (alu_drop || lsb_drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (DEPTH = 4): a vector table for the basic
// broadcast / round-robin / backlog behaviour, then hand sequences for clear,
// rdy freeze, overflow and mid-operation reset.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        alu_flag, lsb_flag;
  logic [3:0]  alu_reorder, lsb_reorder;
  logic [31:0] alu_val, lsb_val;
  logic        alu_stall, lsb_stall, cdb_flag, cdb_src, ovf;
  logic [3:0]  cdb_reorder;
  logic [31:0] cdb_val;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .alu_flag(alu_flag), .alu_reorder(alu_reorder), .alu_val(alu_val),
    .lsb_flag(lsb_flag), .lsb_reorder(lsb_reorder), .lsb_val(lsb_val),
    .alu_stall(alu_stall), .lsb_stall(lsb_stall),
    .cdb_flag(cdb_flag), .cdb_reorder(cdb_reorder), .cdb_val(cdb_val),
    .cdb_src(cdb_src), .ovf(ovf)
  );

  typedef struct {
    logic        rst, rdy, clr;
    logic        af;
    logic [3:0]  ar;
    logic [31:0] av;
    logic        lf;
    logic [3:0]  lr;
    logic [31:0] lv;
    logic        ef;
    logic [3:0]  er;
    logic [31:0] ev;
    logic        es, eas, els, eov;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs sampled 1 time unit after the posedge.
  task automatic step(input logic r, input logic rd, input logic cl,
                      input logic af, input logic [3:0] ar, input logic [31:0] av,
                      input logic lf, input logic [3:0] lr, input logic [31:0] lv);
    @(negedge clk);
    rst = r; rdy = rd; clear = cl;
    alu_flag = af; alu_reorder = ar; alu_val = av;
    lsb_flag = lf; lsb_reorder = lr; lsb_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
  endtask

  task automatic both(input logic [3:0] i);
    step(0, 1, 0, 1, i, 32'h100 + 32'(i), 1, i, 32'h200 + 32'(i));
  endtask

  int unsigned alu_next, lsb_next, nalu, nlsb;

  task automatic observe();
    if (cdb_flag) begin
      if (cdb_src == 1'b0) begin
        chk("ovf_alu_order", {28'h0, cdb_reorder}, alu_next);
        chk("ovf_alu_val", cdb_val, 32'h100 + alu_next);
        alu_next++;
        nalu++;
      end else begin
        chk("ovf_lsb_order", {28'h0, cdb_reorder}, lsb_next);
        chk("ovf_lsb_val", cdb_val, 32'h200 + lsb_next);
        lsb_next++;
        nlsb++;
      end
    end
  endtask

  initial begin
    rst = 1; rdy = 1; clear = 0;
    alu_flag = 0; alu_reorder = 0; alu_val = 0;
    lsb_flag = 0; lsb_reorder = 0; lsb_val = 0;

    // rst rdy clr | af ar av | lf lr lv | ef er ev es | astall lstall ovf
    tbl.push_back('{1,1,0, 0,4'd0,32'h00, 0,4'd0,32'h00, 0,4'd0,32'h00,0, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd3,32'hAA, 0,4'd0,32'h00, 1,4'd3,32'hAA,0, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0,32'h00, 0,4'd3,32'hAA,0, 0,0,0});
    tbl.push_back('{1,1,0, 0,4'd0,32'h00, 0,4'd0,32'h00, 0,4'd0,32'h00,0, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd1,32'h11, 1,4'd2,32'h22, 1,4'd1,32'h11,0, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd4,32'h44, 1,4'd5,32'h55, 1,4'd2,32'h22,1, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0,32'h00, 1,4'd4,32'h44,0, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0,32'h00, 1,4'd5,32'h55,1, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0,32'h00, 0,4'd5,32'h55,1, 0,0,0});
    // both sources every cycle for 6 cycles, then drain
    tbl.push_back('{0,1,0, 1,4'd0,32'hA0, 1,4'd8, 32'hB0, 1,4'd0, 32'hA0,0, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd1,32'hA1, 1,4'd9, 32'hB1, 1,4'd8, 32'hB0,1, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd2,32'hA2, 1,4'd10,32'hB2, 1,4'd1, 32'hA1,0, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd3,32'hA3, 1,4'd11,32'hB3, 1,4'd9, 32'hB1,1, 0,0,0});
    tbl.push_back('{0,1,0, 1,4'd4,32'hA4, 1,4'd12,32'hB4, 1,4'd2, 32'hA2,0, 0,1,0});
    tbl.push_back('{0,1,0, 1,4'd5,32'hA5, 1,4'd13,32'hB5, 1,4'd10,32'hB2,1, 1,1,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 1,4'd3, 32'hA3,0, 0,1,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 1,4'd11,32'hB3,1, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 1,4'd4, 32'hA4,0, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 1,4'd12,32'hB4,1, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 1,4'd5, 32'hA5,0, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 1,4'd13,32'hB5,1, 0,0,0});
    tbl.push_back('{0,1,0, 0,4'd0,32'h00, 0,4'd0, 32'h00, 0,4'd13,32'hB5,1, 0,0,0});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].clr, tbl[i].af, tbl[i].ar, tbl[i].av,
           tbl[i].lf, tbl[i].lr, tbl[i].lv);
      chk($sformatf("v%0d_flag", i),    {31'h0, cdb_flag},    {31'h0, tbl[i].ef});
      chk($sformatf("v%0d_reorder", i), {28'h0, cdb_reorder}, {28'h0, tbl[i].er});
      chk($sformatf("v%0d_val", i),     cdb_val,              tbl[i].ev);
      chk($sformatf("v%0d_src", i),     {31'h0, cdb_src},     {31'h0, tbl[i].es});
      chk($sformatf("v%0d_astall", i),  {31'h0, alu_stall},   {31'h0, tbl[i].eas});
      chk($sformatf("v%0d_lstall", i),  {31'h0, lsb_stall},   {31'h0, tbl[i].els});
      chk($sformatf("v%0d_ovf", i),     {31'h0, ovf},         {31'h0, tbl[i].eov});
    end

    // clear with both FIFOs at 3 entries
    step(1, 1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    for (int i = 0; i < 6; i++) both(4'(i));
    chk("pre_clear_stall", {30'h0, alu_stall, lsb_stall}, 32'h3);
    step(0, 1, 1, 1, 4'd6, 32'h106, 1, 4'd14, 32'h20E);
    chk("clear_flag", {31'h0, cdb_flag}, 32'h0);
    chk("clear_stall", {30'h0, alu_stall, lsb_stall}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_clear_flag", {31'h0, cdb_flag}, 32'h0);
    end
    step(0, 1, 0, 1, 4'd7, 32'h77, 0, 4'd0, 32'h0);
    chk("after_clear_flag", {31'h0, cdb_flag}, 32'h1);
    chk("after_clear_reorder", {28'h0, cdb_reorder}, 32'h7);
    chk("after_clear_val", cdb_val, 32'h77);

    // rdy low with one queued LSB result
    step(1, 1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    step(0, 1, 0, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
    chk("rdy_pre_flag", {31'h0, cdb_flag}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 4'(4 + i), 32'h40 + 32'(i), 0, 4'd0, 32'h0);
      chk("rdy_low_flag", {31'h0, cdb_flag}, 32'h0);
      chk("rdy_low_hold", {28'h0, cdb_reorder}, 32'h1);
    end
    idle();
    chk("rdy_back_flag", {31'h0, cdb_flag}, 32'h1);
    chk("rdy_back_reorder", {28'h0, cdb_reorder}, 32'h2);
    chk("rdy_back_src", {31'h0, cdb_src}, 32'h1);
    idle();
    chk("rdy_discard_flag", {31'h0, cdb_flag}, 32'h0);

    // overflow: 9 cycles of both sources, 9th LSB result dropped
    step(1, 1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    alu_next = 0; lsb_next = 0; nalu = 0; nlsb = 0;
    for (int i = 0; i < 8; i++) begin
      both(4'(i));
      observe();
    end
    chk("ovf_before", {31'h0, ovf}, 32'h0);
    both(4'd8);
    observe();
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      idle();
      observe();
    end
    chk("ovf_alu_count", nalu, 32'd9);
    chk("ovf_lsb_count", nlsb, 32'd8);
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);

    // reset mid-operation
    for (int i = 0; i < 6; i++) both(4'(i));
    step(1, 1, 0, 1, 4'd9, 32'h9, 1, 4'd9, 32'h9);
    chk("rst_mid_flag", {31'h0, cdb_flag}, 32'h0);
    chk("rst_mid_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_mid_stall", {30'h0, alu_stall, lsb_stall}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_mid_idle_flag", {31'h0, cdb_flag}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
